pmic_seq_timer: RTL

Timer responder to the PMIC power-sequencing FSM. It accepts the FSM's load/en handshake and returns a one-cycle timeOut pulse after a per-step programmable delay. It tracks the sequencing step internally (IO LDO, Analog LDO, Logic LDO, Ready settle), so the FSM needs no delay values. An abort input, driven from Low_BAT | Low_POW, cancels the sequence. The block sits beside the FSM in the PMIC top level and shares its clock.

---
 rtl/pmic_pkg.sv | 31 +++
 rtl/pmic_prescaler.sv | 31 +++
 rtl/pmic_seq_timer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pmic_pkg.sv
// Shared encodings and default delays for the PMIC sequencer timer.
// Delay defaults are in prescaled ticks and are shared with the FSM.
package pmic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [1:0] STEP_IO     = 2'd0;
  localparam logic [1:0] STEP_ANALOG = 2'd1;
  localparam logic [1:0] STEP_LOGIC  = 2'd2;
  localparam logic [1:0] STEP_READY  = 2'd3;

  localparam int DEF_PRESCALE   = 100;
  localparam int DEF_DLY_IO     = 500;
  localparam int DEF_DLY_ANALOG = 1000;
  localparam int DEF_DLY_LOGIC  = 200;
  localparam int DEF_DLY_READY  = 50;
  localparam int DEF_WDOG_TICKS = 4000;

  // True when v is a non-negative value representable in w bits.
  function automatic bit fits(input int v, input int w);
    if (v < 0) return 1'b0;
    if (w >= 32) return 1'b1;
    return longint'(v) < (longint'(1) << w);
  endfunction

endpackage

// File: rtl/pmic_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE unheld cycles.
// clr restarts the phase, hold freezes it.
module pmic_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  assign tick = !clr && !hold && (pre == LAST);

  // Phase counter wraps at PRESCALE-1; frozen while held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (!hold) begin
      pre <= (pre == LAST) ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/pmic_seq_timer.sv
// Per-step settle timer answering the PMIC sequencing FSM.
// Optional watchdog in DONE: define PMIC_TIMER_WDOG_EN.
module pmic_seq_timer
  import pmic_pkg::*;
#(
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int CNT_W      = 16,
  parameter int DLY_IO     = DEF_DLY_IO,
  parameter int DLY_ANALOG = DEF_DLY_ANALOG,
  parameter int DLY_LOGIC  = DEF_DLY_LOGIC,
  parameter int DLY_READY  = DEF_DLY_READY,
  parameter int WDOG_TICKS = DEF_WDOG_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic       abort,
  output logic       timeOut,
  output logic       busy,
  output logic [1:0] step,
  output logic       err_reload,
  output logic       wdog_fault
);

  if (PRESCALE < 1) begin : g_bad_pre
    $error("PRESCALE must be >= 1");
  end
  if (!fits(DLY_IO, CNT_W) || !fits(DLY_ANALOG, CNT_W) ||
      !fits(DLY_LOGIC, CNT_W) || !fits(DLY_READY, CNT_W)) begin : g_bad_dly
    $error("delay constant does not fit in CNT_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic             to_q, to_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] dly;
  logic             active;
  logic             tick;
  logic             fire;

  assign active     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign timeOut    = to_q;
  assign busy       = active;
  assign step       = step_q;
  assign err_reload = err_q;

  pmic_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (abort || load || !active),
    .hold (!en),
    .tick (tick)
  );

  // Delay lookup for the step currently being timed.
  always_comb begin
    dly = '0;
    unique case (1'b1)
      (step_q == STEP_IO):     dly = CNT_W'(DLY_IO);
      (step_q == STEP_ANALOG): dly = CNT_W'(DLY_ANALOG);
      (step_q == STEP_LOGIC):  dly = CNT_W'(DLY_LOGIC);
      (step_q == STEP_READY):  dly = CNT_W'(DLY_READY);
    endcase
  end

  // Next state: abort beats load beats counting. A pending pulse
  // blocks a zero-delay expiry so timeOut never lasts two cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    to_d    = 1'b0;
    err_d   = err_q;
    fire    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      step_d  = STEP_IO;
    end else if (load) begin
      cnt_d = dly;
      if (active && cnt_q != '0) err_d = 1'b1;
      if (dly == '0 && en && !to_q) fire = 1'b1;
      else state_d = en ? ST_RUN : ST_PAUSE;
    end else if (active) begin
      if (!en) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_RUN;
        if (cnt_q == '0) begin
          if (!to_q) fire = 1'b1;
        end else if (tick) begin
          if (cnt_q == CNT_W'(1)) fire = 1'b1;
          else cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
    if (fire) begin
      to_d    = 1'b1;
      state_d = ST_DONE;
      cnt_d   = '0;
      step_d  = (step_q == STEP_READY) ? STEP_READY : step_q + 2'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= STEP_IO;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

`ifdef PMIC_TIMER_WDOG_EN
  if (WDOG_TICKS < 1 || !fits(WDOG_TICKS, CNT_W)) begin : g_bad_wd
    $error("WDOG_TICKS must be >= 1 and fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WDOG_TICKS - 1);

  logic             wd_arm;
  logic             wd_run;
  logic             wd_tick;
  logic             wd_fault_q;
  logic [CNT_W-1:0] wd_cnt;

  assign wd_run     = wd_arm && (state_q == ST_DONE);
  assign wdog_fault = wd_fault_q;

  pmic_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_wd_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (!wd_run || load || abort),
    .hold (1'b0),
    .tick (wd_tick)
  );

  // Watchdog armed by an early-step timeout, cleared by load/abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_arm     <= 1'b0;
      wd_cnt     <= '0;
      wd_fault_q <= 1'b0;
    end else if (abort) begin
      wd_arm <= 1'b0;
      wd_cnt <= '0;
    end else if (fire) begin
      wd_arm <= (step_q != STEP_READY);
      wd_cnt <= '0;
    end else if (load) begin
      wd_arm <= 1'b0;
      wd_cnt <= '0;
    end else if (wd_tick) begin
      if (wd_cnt == WD_LAST) begin
        wd_fault_q <= 1'b1;
        wd_arm     <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign wdog_fault = 1'b0;
`endif

endmodule
